// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 MIPS register file with write-back select; define REGFILE_BYPASS_EN for write-through reads
module reg_file_wb #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  MemtoReg,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_data,
  input  logic [31:0] pc_plus4,
  output logic [31:0] read_d1,
  output logic [31:0] read_d2,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wr_done,
  output logic [4:0]  last_wr_addr
);
  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];
  logic        wr_done_d, wr_done_q;
  logic [4:0]  last_wr_addr_d, last_wr_addr_q;
  logic        rsv, commit;
  always_comb begin
    rsv = (RegDst == 2'b11) || (MemtoReg == 2'b11);
    wb_addr = rsv ? 5'd0 : RegDst == 2'b00 ? rt : RegDst == 2'b01 ? rd : 5'd31;
    wb_data = rsv ? 32'd0 : MemtoReg == 2'b00 ? alu_result : MemtoReg == 2'b01 ? mem_data : pc_plus4;
    commit = rst_n && RegWrite && !rsv && (wb_addr != 5'd0);
    regs_d = regs_q;
    if (commit) regs_d[wb_addr] = wb_data;
    wr_done_d = commit;
    last_wr_addr_d = commit ? wb_addr : last_wr_addr_q;
  end
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_d1 = (rs == 5'd0) ? 32'd0 : (commit && rs == wb_addr) ? wb_data : regs_q[rs];
    read_d2 = (rt == 5'd0) ? 32'd0 : (commit && rt == wb_addr) ? wb_data : regs_q[rt];
  end
`else
  always_comb begin
    read_d1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    read_d2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 32'd0;
      wr_done_q <= 1'b0;
      last_wr_addr_q <= 5'd0;
    end else begin
      regs_q <= regs_d;
      wr_done_q <= wr_done_d;
      last_wr_addr_q <= last_wr_addr_d;
    end
  end
  assign wr_done = wr_done_q;
  assign last_wr_addr = last_wr_addr_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized check of reg_file_wb against an array-based register model
module tb_reg_file_wb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk, rst_n, RegWrite;
  logic [1:0] RegDst, MemtoReg;
  logic [4:0] rs, rt, rd;
  logic [31:0] alu_result, mem_data, pc_plus4;
  logic [31:0] read_d1, read_d2, wb_data;
  logic [4:0] wb_addr, last_wr_addr;
  logic wr_done;
  logic [31:0] model [32];
  logic exp_done;
  logic [4:0] exp_last;
  int n_chk = 0;
  int n_pass = 0;

  reg_file_wb dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .rs(rs), .rt(rt), .rd(rd), .alu_result(alu_result), .mem_data(mem_data), .pc_plus4(pc_plus4),
    .read_d1(read_d1), .read_d2(read_d2), .wb_addr(wb_addr), .wb_data(wb_data),
    .wr_done(wr_done), .last_wr_addr(last_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    exp_done = 1'b0;
    exp_last = 5'd0;
  endtask

  task automatic cycle(input logic we, input logic [1:0] dst, input logic [1:0] mtr,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    logic [4:0] a;
    logic [31:0] v, e1, e2;
    logic c;
    RegWrite = we; RegDst = dst; MemtoReg = mtr;
    rs = s; rt = t; rd = d;
    alu_result = alu; mem_data = mem; pc_plus4 = pc;
    if (dst == 2'd3 || mtr == 2'd3) begin
      a = 5'd0;
      v = 32'd0;
    end else begin
      case (dst)
        2'd0: a = t;
        2'd1: a = d;
        default: a = 5'd31;
      endcase
      case (mtr)
        2'd0: v = alu;
        2'd1: v = mem;
        default: v = pc;
      endcase
    end
    c = we && a != 5'd0;
    e1 = (s == 5'd0) ? 32'd0 : (BYP && c && s == a) ? v : model[s];
    e2 = (t == 5'd0) ? 32'd0 : (BYP && c && t == a) ? v : model[t];
    #1;
    check("wb_addr", {27'd0, wb_addr}, {27'd0, a});
    check("wb_data", wb_data, v);
    check("read_d1", read_d1, e1);
    check("read_d2", read_d2, e2);
    @(posedge clk);
    #1;
    if (c) begin
      model[a] = v;
      exp_last = a;
    end
    exp_done = c;
    check("wr_done", {31'd0, wr_done}, {31'd0, exp_done});
    check("last_wr_addr", {27'd0, last_wr_addr}, {27'd0, exp_last});
  endtask

  task automatic rd_only(input logic [4:0] s, input logic [4:0] t);
    cycle(1'b0, 2'd1, 2'd0, s, t, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    RegWrite = 1'b1; RegDst = 2'b01; MemtoReg = 2'b00;
    rs = 5'd5; rt = 5'd5; rd = 5'd5;
    alu_result = 32'h1234_5678; mem_data = 32'd0; pc_plus4 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_d1", read_d1, 32'd0);
    check("rst_wr_done", {31'd0, wr_done}, 32'd0);
    check("rst_last", {27'd0, last_wr_addr}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd5);
    check("rst_wb_data", wb_data, 32'h1234_5678);
    rst_n = 1'b1;
    // directed test plan items
    cycle(1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 5'd8, 32'h0000_002A, 32'd0, 32'd0);
    rd_only(5'd8, 5'd0);
    check("alu_wb", read_d1, 32'h0000_002A);
    cycle(1'b1, 2'b00, 2'b01, 5'd9, 5'd9, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'd0);
    cycle(1'b1, 2'b10, 2'b10, 5'd31, 5'd9, 5'd0, 32'd0, 32'd0, 32'h0040_0010);
    rd_only(5'd9, 5'd31);
    check("load_wb", read_d1, 32'hDEAD_BEEF);
    check("link_wb", read_d2, 32'h0040_0010);
    cycle(1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    check("zero_done", {31'd0, wr_done}, 32'd0);
    cycle(1'b1, 2'b01, 2'b11, 5'd8, 5'd9, 5'd8, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    cycle(1'b1, 2'b11, 2'b00, 5'd8, 5'd9, 5'd8, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    rd_only(5'd8, 5'd9);
    cycle(1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 5'd4, 32'h11, 32'd0, 32'd0);
    cycle(1'b1, 2'b01, 2'b00, 5'd0, 5'd4, 5'd4, 32'h22, 32'd0, 32'd0);
    rd_only(5'd0, 5'd4);
    check("collide_after", read_d2, 32'h22);
    cycle(1'b1, 2'b01, 2'b00, 5'd6, 5'd0, 5'd6, 32'hA, 32'd0, 32'd0);
    cycle(1'b1, 2'b01, 2'b00, 5'd6, 5'd0, 5'd6, 32'hB, 32'd0, 32'd0);
    rd_only(5'd6, 5'd6);
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
    // asynchronous reset asserted mid-cycle with a write pending
    RegWrite = 1'b1; RegDst = 2'b01; MemtoReg = 2'b00;
    rs = 5'd9; rt = 5'd31; rd = 5'd9; alu_result = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_read_d1", read_d1, 32'd0);
    check("arst_read_d2", read_d2, 32'd0);
    check("arst_wr_done", {31'd0, wr_done}, 32'd0);
    check("arst_last", {27'd0, last_wr_addr}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold", read_d1, 32'd0);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i += 2) rd_only(5'(i), 5'(i + 1));
    for (int k = 0; k < 200; k++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
    for (int i = 0; i < 32; i += 2) rd_only(5'(i), 5'(i + 1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
